enc_stream: RTL and testbench

//   Sequential encoder: inverse of the 2-to-4 enable decoder in the combinational-logic set.

---
 rtl/enc_stream_if.sv | 28 ++
 rtl/enc_stream.sv | 92 +++++++++
 tb/tb_enc_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/enc_stream_if.sv
// Stream interface for enc_stream: bitmap load side plus index beat output side.
// master = the encoder, slave = whoever loads bitmaps and consumes index beats.
interface enc_stream_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         i_en;
    logic [N-1:0] i_in;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_out;
    logic         o_last;
    logic         i_ready;
    logic         o_busy_dbg;

    // Load: bitmap taken when i_en && o_ready. Beat: taken when o_valid && i_ready;
    // o_out/o_last stay stable while o_valid && !i_ready.
    modport master (
        input  i_en, i_in, i_ready,
        output o_ready, o_valid, o_out, o_last, o_busy_dbg
    );

    modport slave (
        output i_en, i_in, i_ready,
        input  o_ready, o_valid, o_out, o_last, o_busy_dbg
    );
endinterface

// File: rtl/enc_stream.sv
// Sequential bitmap-to-index encoder: one valid/ready beat per set bit, LSB first.
// Define ENC_MSB_FIRST_EN to emit the highest set bit first instead.
module enc_stream #(
    parameter int N = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    enc_stream_if.master  bus
);
    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_mask;
    logic         single_bit;
    logic         accept;
    logic         beat_done;

    // Beat content comes only from the registered pending bits, never from i_in.
    always_comb begin
        sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) sel_idx = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = W'(i);
        end
`endif
        sel_mask          = '0;
        sel_mask[sel_idx] = 1'b1;
        single_bit        = ((pending_q & (pending_q - ONE)) == '0);
    end

    assign accept    = (state_q == IDLE) && bus.i_en && (bus.i_in != '0);
    assign beat_done = (state_q == EMIT) && bus.i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d = bus.i_in;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (beat_done) begin
                    pending_d = pending_q & ~sel_mask;
                    if (single_bit) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.o_ready    = 1'b1;
        bus.o_valid    = 1'b0;
        bus.o_out      = '0;
        bus.o_last     = 1'b0;
        bus.o_busy_dbg = (state_q == EMIT);
        if (state_q == EMIT) begin
            bus.o_ready = 1'b0;
            bus.o_valid = 1'b1;
            bus.o_out   = sel_idx;
            bus.o_last  = single_bit;
        end
    end
endmodule

// File: tb/tb_enc_stream.sv
// Directed bench for enc_stream: expected beats queued at load time, checked as the
// encoder emits them, and decoded back to a bitmap for the round-trip check.
module tb_enc_stream;
    localparam int N = 4;
    localparam int W = 2;

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    logic [W:0]   exp_q[$];
    logic [N-1:0] acc;

    enc_stream_if #(.N(N)) bus ();

    enc_stream #(.N(N)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] dec2to4(input logic en, input logic [W-1:0] sel);
        logic [N-1:0] one;
        one = 1;
        return en ? (one << sel) : '0;
    endfunction

    // scoreboard entries are {last, index} in emit order
    task automatic push_beats(input logic [N-1:0] b);
        int cnt;
        int seen;
        logic [W-1:0] idx;
        cnt  = $countones(b);
        seen = 0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
`else
        for (int i = 0; i < N; i++) begin
`endif
            if (b[i]) begin
                seen++;
                idx = i[W-1:0];
                exp_q.push_back({(seen == cnt), idx});
            end
        end
    endtask

    // driver: call at posedge+1 with the encoder idle; returns at accept edge +1
    task automatic load(input logic [N-1:0] b);
        bus.i_en = 1'b1;
        bus.i_in = b;
        push_beats(b);
        @(posedge clk);
        #1;
        bus.i_en = 1'b0;
        bus.i_in = N'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!bus.o_ready && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'd0, bus.o_ready}, 32'd1);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    // monitor: compare each presented beat with the queue head, pop on handshake
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            chk("ready_vs_valid", {31'd0, bus.o_ready}, {31'd0, !bus.o_valid});
            if (bus.o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {31'd0, bus.o_valid}, 32'd0);
                end else begin
                    chk("beat_idx", {30'd0, bus.o_out}, {30'd0, exp_q[0][W-1:0]});
                    chk("beat_last", {31'd0, bus.o_last}, {31'd0, exp_q[0][W]});
                    if (bus.i_ready) begin
                        acc = acc | dec2to4(1'b1, bus.o_out);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rstn       = 1'b1;
        bus.i_en   = 1'b0;
        bus.i_in   = '0;
        bus.i_ready = 1'b0;
        acc        = '0;

        // 1: async reset mid-clock, checked before any edge
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_out",   {30'd0, bus.o_out},   32'd0);
        chk("rst_last",  {31'd0, bus.o_last},  32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 2: 1010 at full rate
        bus.i_ready = 1'b1;
        load(4'b1010);
        @(negedge clk);
        chk("t2_first_valid", {31'd0, bus.o_valid}, 32'd1);
`ifdef ENC_MSB_FIRST_EN
        chk("t2_first_idx", {30'd0, bus.o_out}, 32'd3);
`else
        chk("t2_first_idx", {30'd0, bus.o_out}, 32'd1);
`endif
        @(posedge clk);
        #1;
        chk("t2_busy_mid", {31'd0, bus.o_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t2_ready_after_last", {31'd0, bus.o_ready}, 32'd1);
        chk("t2_drained", exp_q.size(), 32'd0);

        // 3: 0110 under backpressure for 3 cycles
        bus.i_ready = 1'b0;
        load(4'b0110);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, bus.o_valid}, 32'd1);
`ifdef ENC_MSB_FIRST_EN
            chk("t3_hold_idx", {30'd0, bus.o_out}, 32'd2);
`else
            chk("t3_hold_idx", {30'd0, bus.o_out}, 32'd1);
`endif
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        wait_idle("t3_done", 10);

        // 4: empty bitmap, then a load attempt while busy
        load(4'b0000);
        @(negedge clk);
        chk("t4_zero_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("t4_zero_ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        load(4'b0101);
        bus.i_en = 1'b1;
        bus.i_in = 4'b1111;
        @(posedge clk);
        #1;
        bus.i_en = 1'b0;
        chk("t4_still_busy", {31'd0, bus.o_valid}, 32'd1);
        bus.i_ready = 1'b1;
        wait_idle("t4_done", 10);
        repeat (3) @(posedge clk);
        #1;

        // 5: reset after the second beat of 1111, then a single-bit load
        load(4'b1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("t5_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("t5_rst_out",   {30'd0, bus.o_out},   32'd0);
        chk("t5_rst_last",  {31'd0, bus.o_last},  32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_post_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        @(posedge clk);
        #1;
        load(4'b1000);
        @(negedge clk);
        chk("t5_single_idx",  {30'd0, bus.o_out},  32'd3);
        chk("t5_single_last", {31'd0, bus.o_last}, 32'd1);
        wait_idle("t5_done", 10);

        // 6: round trip through the 2-to-4 decoder with random backpressure
        for (int b = 1; b < 16; b++) begin
            int n;
            acc = '0;
            load(b[N-1:0]);
            n = 0;
            while (!bus.o_ready && n < 100) begin
                bus.i_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                n++;
            end
            chk("t6_idle", {31'd0, bus.o_ready}, 32'd1);
            chk("t6_roundtrip", {28'd0, acc}, b);
            chk("t6_drained", exp_q.size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
